// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction fetch stage with pipelined i-cache requests,
//               first-word-fall-through instruction buffer and redirect squash
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ic_req_valid,
  input  logic              ic_req_ready,
  output logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_resp_valid,
  input  logic [31:0]       ic_resp_inst,
  input  logic              ic_resp_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic              out_error
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + 33;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              drop_resp;
  logic              req_fire;
  logic [CNT_W-1:0]  inflight_eff;
  logic [CNT_W-1:0]  drop_eff;
  logic [OCC_W-1:0]  count_eff;
  logic [31:0]       live_eff;
  logic [ENT_W-1:0]  head;

  always_comb begin
    fifo_empty = (count_q == '0);
    out_valid  = !fifo_empty && !redirect_valid;
    pop        = out_valid && out_ready;

    // A response landing in a redirect cycle belongs to the old stream.
    drop_resp    = ic_resp_valid && (redirect_valid || (drop_cnt_q != '0));
    push         = ic_resp_valid && !drop_resp;
    inflight_eff = inflight_q - CNT_W'(ic_resp_valid);

    if (redirect_valid) begin
      drop_eff  = inflight_eff;
      count_eff = '0;
    end else begin
      drop_eff  = drop_cnt_q - CNT_W'(drop_resp);
      count_eff = count_q + OCC_W'(push) - OCC_W'(pop);
    end

    halted_d = redirect_valid ? 1'b0 : (halted_q || (push && ic_resp_error));

    // Buffer slots already promised: live requests plus stored entries.
    live_eff = 32'(inflight_eff) - 32'(drop_eff) + 32'(count_eff);

    ic_req_addr  = redirect_valid ? redirect_pc : fetch_pc_q;
    ic_req_valid = !rst && !halted_d
                   && (32'(inflight_eff) < 32'(MAX_OUTSTANDING))
                   && (live_eff < 32'(DEPTH));
    req_fire     = ic_req_valid && ic_req_ready;

    fetch_pc_d = fetch_pc_q;
    if (req_fire) begin
      fetch_pc_d = ic_req_addr + ADDR_W'(4);
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end

    inflight_d = inflight_eff + CNT_W'(req_fire);
    drop_cnt_d = drop_eff;

    resp_pc_d = resp_pc_q;
    if (redirect_valid) begin
      resp_pc_d = redirect_pc;
    end else if (push) begin
      resp_pc_d = resp_pc_q + ADDR_W'(4);
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {resp_pc_q, ic_resp_inst, ic_resp_error};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    count_d = count_eff;

    head      = mem_q[rd_ptr_q];
    out_pc    = fifo_empty ? '0 : head[ENT_W-1:33];
    out_inst  = fifo_empty ? '0 : head[32:1];
    out_error = fifo_empty ? 1'b0 : head[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      halted_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      halted_q   <= halted_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == OCC_W'(DEPTH))))
        else $error("fetch_queue: push into full instruction buffer");
    end
  end
`endif

endmodule
`default_nettype wire
